// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: aluop classes,
// decoded ALU controls and the shifter control states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_R     = 3'b000,
        OP_I     = 3'b001,
        OP_BR    = 3'b010,
        OP_JAL   = 3'b011,
        OP_LOAD  = 3'b100,
        OP_STORE = 3'b101,
        OP_LUI   = 3'b110,
        OP_NONE  = 3'b111
    } aluop_e;

    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        BEQ, BNE, BLT, BGE, BLTU, BGEU, PASSB, ILLEGAL
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE, SHIFT, DONE
    } state_e;

    function automatic logic is_shift(alu_ctrl_e c);
        return (c == SLL) || (c == SRL) || (c == SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between operand muxing,
// the ALU execute unit and writeback.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      aluop_i;
    logic [2:0]      funct3_i;
    logic            funct7b5_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            branch_taken_o;
    logic            illegal_o;

    modport master (
        output in_valid_i, aluop_i, funct3_i, funct7b5_i,
        output op_a_i, op_b_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o,
        input  branch_taken_o, illegal_o
    );

    modport slave (
        input  in_valid_i, aluop_i, funct3_i, funct7b5_i,
        input  op_a_i, op_b_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o,
        output branch_taken_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of aluop class plus funct3/funct7[5]
// into a concrete ALU control.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [2:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_ctrl_e  ctrl_o
);
    aluop_e op;
    assign op = aluop_e'(aluop_i);

    always_comb begin
        ctrl_o = ILLEGAL;
        unique case (op)
            OP_R, OP_I: begin
                unique case (funct3_i)
                    // Immediate form has no subtract encoding.
                    3'b000: ctrl_o = (op == OP_R && funct7b5_i) ? SUB : ADD;
                    3'b001: ctrl_o = SLL;
                    3'b010: ctrl_o = SLT;
                    3'b011: ctrl_o = SLTU;
                    3'b100: ctrl_o = XOR;
                    3'b101: ctrl_o = funct7b5_i ? SRA : SRL;
                    3'b110: ctrl_o = OR;
                    3'b111: ctrl_o = AND;
                    default: ctrl_o = ILLEGAL;
                endcase
            end
            OP_BR: begin
                case (funct3_i)
                    3'b000:  ctrl_o = BEQ;
                    3'b001:  ctrl_o = BNE;
                    3'b100:  ctrl_o = BLT;
                    3'b101:  ctrl_o = BGE;
                    3'b110:  ctrl_o = BLTU;
                    3'b111:  ctrl_o = BGEU;
                    default: ctrl_o = ILLEGAL;
                endcase
            end
            OP_JAL, OP_LOAD, OP_STORE: ctrl_o = ADD;
            OP_LUI:  ctrl_o = PASSB;
            default: ctrl_o = ILLEGAL;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decode, compute, optional bit-serial
// shifter, registered result over a valid/ready handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit SERIAL_SHIFT = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_exec_unit_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    state_e          state;
    alu_ctrl_e       dec_op;
    alu_ctrl_e       op_q;
    logic [XLEN-1:0] work;
    logic [SW-1:0]   cnt;
    logic [XLEN-1:0] res_q;
    logic            taken_q;
    logic            ill_q;

    logic [SW-1:0]   shamt;
    logic            accept;
    logic            go_serial;
    logic [XLEN-1:0] calc_res;
    logic            calc_taken;
    logic [XLEN-1:0] step;
    logic            lt_s;
    logic            lt_u;

    alu_ctrl_dec u_dec (
        .aluop_i    (bus.aluop_i),
        .funct3_i   (bus.funct3_i),
        .funct7b5_i (bus.funct7b5_i),
        .ctrl_o     (dec_op)
    );

    assign bus.in_ready_o     = (state == IDLE) && !rst_i;
    assign bus.out_valid_o    = (state == DONE);
    assign bus.result_o       = res_q;
    assign bus.branch_taken_o = taken_q;
    assign bus.illegal_o      = ill_q;

    assign accept    = bus.in_valid_i && bus.in_ready_o;
    assign shamt     = bus.op_b_i[SW-1:0];
    assign go_serial = SERIAL_SHIFT && is_shift(dec_op) && (shamt != '0);
    assign lt_s      = $signed(bus.op_a_i) < $signed(bus.op_b_i);
    assign lt_u      = bus.op_a_i < bus.op_b_i;

    always_comb begin
        calc_res   = '0;
        calc_taken = 1'b0;
        unique case (dec_op)
            ADD:   calc_res = bus.op_a_i + bus.op_b_i;
            SUB:   calc_res = bus.op_a_i - bus.op_b_i;
            SLL:   calc_res = bus.op_a_i << shamt;
            SLT:   calc_res = XLEN'(lt_s);
            SLTU:  calc_res = XLEN'(lt_u);
            XOR:   calc_res = bus.op_a_i ^ bus.op_b_i;
            SRL:   calc_res = bus.op_a_i >> shamt;
            SRA:   calc_res = $signed(bus.op_a_i) >>> shamt;
            OR:    calc_res = bus.op_a_i | bus.op_b_i;
            AND:   calc_res = bus.op_a_i & bus.op_b_i;
            BEQ:   calc_taken = (bus.op_a_i == bus.op_b_i);
            BNE:   calc_taken = (bus.op_a_i != bus.op_b_i);
            BLT:   calc_taken = lt_s;
            BGE:   calc_taken = !lt_s;
            BLTU:  calc_taken = lt_u;
            BGEU:  calc_taken = !lt_u;
            PASSB: calc_res = bus.op_b_i;
            default: calc_res = '0;
        endcase
        if (calc_taken)
            calc_res = XLEN'(1'b1);
    end

    // One-bit step of the serial shifter; sra keeps the sign bit.
    always_comb begin
        step = work >> 1;
        unique case (op_q)
            SLL:     step = work << 1;
            SRA:     step = {work[XLEN-1], work[XLEN-1:1]};
            default: step = work >> 1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            op_q    <= ADD;
            work    <= '0;
            cnt     <= '0;
            res_q   <= '0;
            taken_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (go_serial) begin
                            work  <= bus.op_a_i;
                            cnt   <= shamt;
                            op_q  <= dec_op;
                            state <= SHIFT;
                        end else begin
                            res_q   <= calc_res;
                            taken_q <= calc_taken;
                            ill_q   <= (dec_op == ILLEGAL);
                            state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work <= step;
                    cnt  <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        res_q   <= step;
                        taken_q <= 1'b0;
                        ill_q   <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors, a
// decoupled monitor, backpressure and reset-mid-shift cases.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(
        .XLEN         (32),
        .SERIAL_SHIFT (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        taken;
        logic        ill;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        taken;
        logic        ill;
        int          lat;
    } vec_t;

    exp_t q[$];
    bit   seen = 1'b0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: compares each presented result against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none",
                         bus.result_o);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc), 32'(q[0].due));
                    seen = 1'b1;
                end
                if (bus.out_ready_i) begin
                    e = q.pop_front();
                    chk("result", bus.result_o, e.res);
                    chk("taken", 32'(bus.branch_taken_o), 32'(e.taken));
                    chk("illegal", 32'(bus.illegal_o), 32'(e.ill));
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input vec_t v, input bit push, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected 1");
        end
        bus.in_valid_i = 1'b1;
        bus.aluop_i    = v.op;
        bus.funct3_i   = v.f3;
        bus.funct7b5_i = v.f7;
        bus.op_a_i     = v.a;
        bus.op_b_i     = v.b;
        t = cyc;
        if (push)
            q.push_back('{v.res, v.taken, v.ill, t + v.lat});
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    vec_t vecs[] = '{
        '{3'b000, 3'b000, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1},
        '{3'b000, 3'b000, 1'b1, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1},
        '{3'b000, 3'b101, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 5},
        '{3'b000, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h80000000, 1'b0, 1'b0, 1},
        '{3'b000, 3'b101, 1'b0, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0, 5},
        '{3'b010, 3'b110, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1},
        '{3'b010, 3'b100, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1},
        '{3'b111, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1},
        '{3'b110, 3'b000, 1'b0, 32'd0, 32'h12345000, 32'h12345000, 1'b0, 1'b0, 1},
        '{3'b010, 3'b011, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1},
        '{3'b001, 3'b000, 1'b1, 32'd10, 32'd3, 32'd13, 1'b0, 1'b0, 1},
        '{3'b001, 3'b101, 1'b0, 32'hF0, 32'd4, 32'h0F, 1'b0, 1'b0, 5},
        '{3'b000, 3'b001, 1'b0, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0, 32},
        '{3'b000, 3'b001, 1'b0, 32'd1, 32'h21, 32'd2, 1'b0, 1'b0, 2},
        '{3'b000, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1},
        '{3'b000, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1},
        '{3'b000, 3'b100, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0, 1},
        '{3'b000, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1},
        '{3'b000, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0, 1},
        '{3'b011, 3'b000, 1'b0, 32'h1000, 32'd8, 32'h1008, 1'b0, 1'b0, 1},
        '{3'b100, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1},
        '{3'b010, 3'b000, 1'b0, 32'd7, 32'd7, 32'd1, 1'b1, 1'b0, 1},
        '{3'b010, 3'b001, 1'b0, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1},
        '{3'b010, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1},
        '{3'b010, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1, 1'b0, 1}
    };

    initial begin
        int t;
        int stale;
        vec_t v;
        bus.in_valid_i  = 1'b0;
        bus.aluop_i     = 3'b000;
        bus.funct3_i    = 3'b000;
        bus.funct7b5_i  = 1'b0;
        bus.op_a_i      = '0;
        bus.op_b_i      = '0;
        bus.out_ready_i = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_taken", 32'(bus.branch_taken_o), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
        chk("rst_ready", 32'(bus.in_ready_o), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b1, t);
            for (int k = 1; k <= vecs[i].lat; k++) begin
                @(negedge clk);
                chk("busy_ready", 32'(bus.in_ready_o), 32'd0);
            end
        end
        drain();

        // Backpressure: result held, new requests ignored.
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        v = '{3'b000, 3'b000, 1'b0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1};
        issue(v, 1'b1, t);
        bus.in_valid_i = 1'b1;
        bus.aluop_i    = 3'b110;
        bus.op_b_i     = 32'hDEAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid_o), 32'd1);
            chk("bp_result", bus.result_o, 32'd123);
            chk("bp_ready", 32'(bus.in_ready_o), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", 32'(bus.in_ready_o), 32'd1);
        chk("bp_idle_valid", 32'(bus.out_valid_o), 32'd0);
        drain();

        // Reset in the middle of a long serial shift.
        v = '{3'b000, 3'b001, 1'b0, 32'd1, 32'd20, 32'd0, 1'b0, 1'b0, 21};
        issue(v, 1'b0, t);
        while (cyc < t + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_rst_result", bus.result_o, 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready_o), 32'd1);
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid_o) stale++;
        end
        chk("no_stale", 32'(stale), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Consumer side of the 3-bit aluop control code produced by the core's aluop generator.
- Decodes aluop_i with funct3/funct7[5] into a concrete ALU operation, then executes it on two XLEN operands.
- Returns a registered result over a valid/ready handshake.
- Shifts may run bit-serially (one bit per cycle), so the block holds a small control FSM; it sits in the execute stage between operand muxing and writeback/branch logic.

Parameters:
- XLEN, 32, operand/result width.
- SERIAL_SHIFT, 1, 1 = shifts iterate one bit per cycle; 0 = shifts finish in one cycle like all other ops.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operation request valid.
- in_ready_o  output  1  unit can accept a request.
- aluop_i  input  3  class: 000 R, 001 I, 010 branch, 011 jal/jalr, 100 load, 101 store, 110 lui, 111 none/invalid.
- funct3_i  input  3  instruction funct3.
- funct7b5_i  input  1  instruction bit 30.
- op_a_i  input  XLEN  operand A (rs1/pc).
- op_b_i  input  XLEN  operand B (rs2/imm).
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts result.
- result_o  output  XLEN  ALU result.
- branch_taken_o  output  1  branch compare outcome; 0 for non-branch ops.
- illegal_o  output  1  request had an undecodable aluop/funct3 combination.

Behaviour:
- Reset: state IDLE; out_valid_o=0, result_o=0, branch_taken_o=0, illegal_o=0, shift counter=0; in_ready_o=0 while rst_i=1.
- Reset during SHIFT or DONE: abandon the operation; no result is emitted.
- Decode, aluop 000 (R) by funct3:
  - 000: add, or sub if funct7b5=1.
  - 001 sll; 010 slt (signed); 011 sltu; 100 xor.
  - 101: srl, or sra if funct7b5=1.
  - 110 or; 111 and.
- Decode, aluop 001 (I): as R, except funct3=000 is always add (funct7b5 ignored).
- Shift amount = op_b_i[4:0] (log2 XLEN bits).
- Decode, aluop 010 (branch): funct3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu. result_o={0..,taken}, branch_taken_o=taken. funct3 010/011 -> illegal.
- Decode, aluop 011/100/101: result = op_a+op_b, modulo 2^XLEN.
- Decode, aluop 110 (lui): result = op_b.
- Decode, aluop 111: illegal_o=1, result_o=0, branch_taken_o=0.
- Illegal requests still complete with the normal 1-cycle latency.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready_o=1 only in IDLE (and not in reset).
  - IDLE: on accept (in_valid_i && in_ready_o), latch operands and decode. Go to SHIFT if SERIAL_SHIFT=1, op is a shift and shamt≠0; otherwise compute the result and go to DONE.
  - SHIFT: shift the working register by 1 per cycle (sra replicates the sign bit); decrement the counter; on counter reaching 0 go to DONE.
  - DONE: out_valid_o=1; on out_ready_i go to IDLE.
- Latency, with T = acceptance cycle:
  - Non-shift op, shamt=0, or SERIAL_SHIFT=0: out_valid_o from cycle T+1.
  - Serial shift with shamt=n>0: out_valid_o from cycle T+n+1.
- Throughput: at most one request per 2 cycles; there is no accept while in DONE.
- Backpressure: while out_valid_o=1 and out_ready_i=0, result_o, branch_taken_o and illegal_o are held stable.
- Inputs are ignored outside IDLE; in_valid_i asserted while in_ready_o=0 has no effect.
- result_o, branch_taken_o and illegal_o are don't-care-but-stable when out_valid_o=0, and cleared only by reset.

Decomposition:
- Package alu_pkg:
  - aluop_e enum (the eight codes above).
  - alu_ctrl_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU, PASSB, ILLEGAL).
  - state_e enum (IDLE, SHIFT, DONE).
- Sub-module alu_ctrl_dec: purely combinational (aluop_i, funct3_i, funct7b5_i) -> alu_ctrl_e.
- The top module holds the FSM, datapath and serial shifter.

Test Plan:
- R add/sub: aluop 000, f3 000, a=5, b=7: f7b5=0 -> result 12 at T+1; f7b5=1 -> 0xFFFFFFFE; illegal_o=0.
- Serial sra: aluop 000, f3 101, f7b5=1, a=0x80000000, b=4 -> result 0xF8000000, out_valid_o first high at T+5, in_ready_o low T+1..T+5. With b=0 -> result 0x80000000 at T+1.
- Branch bltu/blt: aluop 010, a=1, b=0xFFFFFFFF: f3 110 -> taken=1, result 1; f3 100 -> taken=0, result 0.
- Illegal/pass: aluop 111 -> illegal_o=1, result 0 at T+1. aluop 110, b=0x12345000 -> result 0x12345000. aluop 010 f3 011 -> illegal_o=1.
- Backpressure: hold out_ready_i=0 for 3 cycles after an add -> out_valid_o, result_o stable; in_ready_o=0; a new in_valid_i is ignored. Release -> IDLE next cycle.
- Reset mid-shift: sll with b=20, assert rst_i at T+3 -> next cycle out_valid_o=0, result_o=0, in_ready_o=1 after rst_i deasserts; no stale result ever appears.
